color_decision: RTL and testbench
=================================

// Module: color_decision
// PURPOSE
//  Consumes REDCOUNT/BLUECOUNT from the image-processor pixel counter once per frame.
//  Classifies each frame as NONE/RED/BLUE, then debounces the class over consecutive frames.
//  Publishes a stable result to the Arduino with a valid/ack handshake.
//  Pulses COUNT_CLEAR so the upstream counter restarts from zero for the next frame.
// PARAMETERS
//  SAMPLE_LINE    80  VGA_PIXEL_Y row at which counts are sampled (after the count band ends)
//  COLOR_THRESH   20  minimum pixel count for a colour to be declared
//  STABLE_FRAMES  3   consecutive identical frame classes required before publishing (1..7)
// PORTS
//  CLK           in   1   system clock (same clock as the pixel counter)
//  RESET         in   1   asynchronous, active-high reset
//  VGA_PIXEL_Y   in   10  current row of the incoming pixel stream
//  REDCOUNT      in   10  red pixel count from the upstream counter
//  BLUECOUNT     in   10  blue pixel count from the upstream counter
//  ACK_IN        in   1   Arduino acknowledge; asynchronous to CLK
//  COUNT_CLEAR   out  1   one-cycle pulse that clears the upstream counts
//  FRAME_CLASS   out  2   class of the most recently sampled frame (debug)
//  RESULT        out  2   published class: 00 none, 01 red, 10 blue (11 never driven)
//  RESULT_VALID  out  1   high while RESULT awaits acknowledge
// BEHAVIOUR
//  Reset
//   - All outputs and internal state go to 0; the FSM enters WAIT_WRAP.
//   - A reset mid-frame therefore never samples a partial frame.
//  FSM (registered; one transition per CLK)
//   - WAIT_WRAP: go to WAIT_LINE when VGA_PIXEL_Y==0.
//   - WAIT_LINE: go to SAMPLE when VGA_PIXEL_Y==SAMPLE_LINE.
//   - SAMPLE: lasts 1 cycle.
//     - Latch the counts and compute the class.
//     - Update the debounce state and FRAME_CLASS.
//     - Go to CLEAR.
//   - CLEAR: lasts 1 cycle; COUNT_CLEAR=1 in this cycle only; go to WAIT_WRAP.
//   - Result: exactly one sample per frame, regardless of how long Y dwells on SAMPLE_LINE.
//  Classification (unsigned 10-bit compares)
//   - RED  if REDCOUNT>=COLOR_THRESH and REDCOUNT>BLUECOUNT.
//   - BLUE if BLUECOUNT>=COLOR_THRESH and BLUECOUNT>REDCOUNT.
//   - NONE otherwise, including equal counts.
//   - FRAME_CLASS updates on the clock edge that ends SAMPLE.
//  Debounce
//   - Registers last_class and stable_cnt (3 bits, saturates at STABLE_FRAMES).
//   - If class==last_class, stable_cnt increments (saturating).
//   - Otherwise last_class<=class and stable_cnt<=1.
//  Publish (evaluated in SAMPLE, using the post-update stable_cnt)
//   - Condition: stable_cnt==STABLE_FRAMES, class!=RESULT, and RESULT_VALID==0.
//   - Action: RESULT<=class and RESULT_VALID<=1.
//   - NONE is publishable.
//   - While RESULT_VALID is high, new stable classes are not published and RESULT holds.
//   - After the ack, the next SAMPLE republishes if the stable class still differs from RESULT.
//  Handshake
//   - ACK_IN passes through a 2-flop synchroniser plus an edge-detect flop.
//   - A rising edge of the synchronised ack clears RESULT_VALID, 3 cycles after ACK_IN rises.
//   - ACK held high does not re-clear or block later results; only rising edges count.
//   - If an ack edge and a publish coincide in the same cycle, the ack clears the old valid.
//     The publish is then suppressed; it occurs at the next SAMPLE.
//  Latency: count to RESULT_VALID is at least STABLE_FRAMES frames, plus 1 cycle after the final SAMPLE.
// TESTING
//  1. Reset: assert RESET asynchronously mid-frame -> all outputs 0 immediately.
//     No SAMPLE occurs until Y passes 0 and then reaches 80.
//  2. Single sample per frame: hold Y at 80 for 176 cycles -> exactly one SAMPLE.
//     Exactly one COUNT_CLEAR pulse, 1 cycle after SAMPLE.
//  3. Red debounce: REDCOUNT=50, BLUECOUNT=5 for 3 frames.
//     -> FRAME_CLASS=01 on every frame; RESULT=01 and RESULT_VALID=1 only after frame 3.
//  4. Threshold and tie: REDCOUNT=19, BLUECOUNT=0 -> FRAME_CLASS=00.
//     REDCOUNT=BLUECOUNT=40 -> FRAME_CLASS=00.
//  5. Interrupted streak: frame classes RED,RED,BLUE,RED,RED,RED -> publish only after frame 6.
//  6. Handshake: with VALID high, feed 3 BLUE frames -> RESULT stays 01.
//     Pulse ACK_IN -> VALID drops 3 cycles later.
//     Next SAMPLE -> RESULT=10 and VALID=1.

Source files
------------

// File: rtl/color_decision_if.sv
// Frame-count inputs, Arduino acknowledge and published result for color_decision.
interface color_decision_if;
   logic [9:0] pixel_y;
   logic [9:0] red_count;
   logic [9:0] blue_count;
   logic       ack;
   logic       count_clear;
   logic [1:0] frame_class;
   logic [1:0] result;
   logic       result_valid;

   // Source side: pixel stream, counter values and the Arduino ack.
   modport master (
      output pixel_y, red_count, blue_count, ack,
      input  count_clear, frame_class, result, result_valid
   );

   // Decision block side.
   modport slave (
      input  pixel_y, red_count, blue_count, ack,
      output count_clear, frame_class, result, result_valid
   );
endinterface

// File: rtl/color_decision.sv
// Per-frame red/blue classifier with multi-frame debounce and a valid/ack
// publish handshake toward the Arduino.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_WRAP | wait for pixel_y to return to row 0 (start of a frame)
// WAIT_LINE | wait for pixel_y to reach SAMPLE_LINE (count band done)
// SAMPLE    | classify counts, update debounce, maybe publish
// CLEAR     | pulse count_clear so the upstream counter restarts
module color_decision #(
   parameter int SAMPLE_LINE   = 80,
   parameter int COLOR_THRESH  = 20,
   parameter int STABLE_FRAMES = 3
) (
   input  logic              clk,
   input  logic              rst,
   color_decision_if.slave   bus
);

   localparam logic [9:0] LINE_Y   = 10'(SAMPLE_LINE);
   localparam logic [9:0] THRESH   = 10'(COLOR_THRESH);
   localparam logic [2:0] STABLE_N = 3'(STABLE_FRAMES);

   localparam logic [1:0] CLS_NONE = 2'b00;
   localparam logic [1:0] CLS_RED  = 2'b01;
   localparam logic [1:0] CLS_BLUE = 2'b10;

   typedef enum logic [1:0] {
      WAIT_WRAP = 2'd0,
      WAIT_LINE = 2'd1,
      SAMPLE    = 2'd2,
      CLEAR     = 2'd3
   } state_t;

   state_t     state;
   logic [1:0] last_class;
   logic [2:0] stable_cnt;
   logic [1:0] frame_class;
   logic [1:0] result;
   logic       result_valid;
   logic       count_clear;

   logic       ack_s1;
   logic       ack_s2;
   logic       ack_d;
   logic       ack_rise;

   logic [1:0] cls;
   logic [2:0] cnt_next;
   logic       publish;

   // Bring the asynchronous ack into clk and keep one delayed copy for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_s1 <= 1'b0;
         ack_s2 <= 1'b0;
         ack_d  <= 1'b0;
      end else begin
         ack_s1 <= bus.ack;
         ack_s2 <= ack_s1;
         ack_d  <= ack_s2;
      end
   end

   assign ack_rise = ack_s2 & ~ack_d;

   // Classify the current counts and work out the post-update debounce count.
   always_comb begin
      cls = CLS_NONE;
      if (bus.red_count >= THRESH && bus.red_count > bus.blue_count)
         cls = CLS_RED;
      else if (bus.blue_count >= THRESH && bus.blue_count > bus.red_count)
         cls = CLS_BLUE;

      cnt_next = 3'd1;
      if (cls == last_class)
         cnt_next = (stable_cnt >= STABLE_N) ? STABLE_N : stable_cnt + 3'd1;

      publish = (cnt_next == STABLE_N) && (cls != result) && !result_valid;
   end

   // Frame sequencing FSM with debounce, publish and ack clear.
   // An ack edge wins over a coinciding publish; that publish retries next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= WAIT_WRAP;
         last_class   <= CLS_NONE;
         stable_cnt   <= 3'd0;
         frame_class  <= CLS_NONE;
         result       <= CLS_NONE;
         result_valid <= 1'b0;
         count_clear  <= 1'b0;
      end else begin
         count_clear <= 1'b0;
         if (ack_rise)
            result_valid <= 1'b0;

         case (state)
            WAIT_WRAP: begin
               if (bus.pixel_y == 10'd0)
                  state <= WAIT_LINE;
            end
            WAIT_LINE: begin
               if (bus.pixel_y == LINE_Y)
                  state <= SAMPLE;
            end
            SAMPLE: begin
               frame_class <= cls;
               last_class  <= cls;
               stable_cnt  <= cnt_next;
               if (publish && !ack_rise) begin
                  result       <= cls;
                  result_valid <= 1'b1;
               end
               count_clear <= 1'b1;
               state       <= CLEAR;
            end
            CLEAR: begin
               state <= WAIT_WRAP;
            end
            default: begin
               state <= WAIT_WRAP;
            end
         endcase
      end
   end

   assign bus.count_clear  = count_clear;
   assign bus.frame_class  = frame_class;
   assign bus.result       = result;
   assign bus.result_valid = result_valid;

endmodule

// File: tb/tb_color_decision.sv
// Directed bench for color_decision: each frame pushes its hand-computed
// {frame_class, result, result_valid} into a queue; a monitor pops and compares
// on every count_clear pulse.
module tb_color_decision;

   logic clk;
   logic rst;
   color_decision_if bus ();

   color_decision dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [4:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one scoreboard entry per count_clear pulse; pulse must be a single cycle.
   initial begin
      logic prev_cc;
      logic [4:0] e;
      prev_cc = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && bus.count_clear === 1'b1) begin
            if (prev_cc)
               check("count_clear_width", 8'd2, 8'd1);
            if (exp_q.size() == 0) begin
               check("unexpected_sample", 8'd1, 8'd0);
            end else begin
               e = exp_q.pop_front();
               check("frame_class",  {6'd0, bus.frame_class}, {6'd0, e[4:3]});
               check("result",       {6'd0, bus.result},      {6'd0, e[2:1]});
               check("result_valid", {7'd0, bus.result_valid}, {7'd0, e[0]});
            end
         end
         prev_cc = (bus.count_clear === 1'b1);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One frame: wrap to row 0, pass the count band, dwell on row 80, move on.
   task automatic frame(input int red, input int blue, input int hold,
                        input logic [1:0] fc, input logic [1:0] res, input logic v);
      exp_q.push_back({fc, res, v});
      @(negedge clk);
      bus.red_count  = 10'(red);
      bus.blue_count = 10'(blue);
      bus.pixel_y    = 10'd0;
      idle(2);
      bus.pixel_y = 10'd40;
      idle(2);
      bus.pixel_y = 10'd80;
      idle(hold);
      bus.pixel_y = 10'd100;
      idle(4);
   endtask

   // Async ack pulse; result_valid must fall on exactly the third edge.
   task automatic ack_pulse(input string name);
      @(posedge clk);
      #2 bus.ack = 1'b1;
      @(posedge clk); #1 check({name, "_edge1"}, {7'd0, bus.result_valid}, 8'd1);
      @(posedge clk); #1 check({name, "_edge2"}, {7'd0, bus.result_valid}, 8'd1);
      @(posedge clk); #1 check({name, "_edge3"}, {7'd0, bus.result_valid}, 8'd0);
      idle(2);
      bus.ack = 1'b0;
      idle(4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      bus.pixel_y    = 10'd100;
      bus.red_count  = 10'd0;
      bus.blue_count = 10'd0;
      bus.ack        = 1'b0;
      #23 rst = 1'b0;
      idle(2);
      check("reset_result_valid", {7'd0, bus.result_valid}, 8'd0);
      check("reset_result",       {6'd0, bus.result},       8'd0);

      // Red debounce: publish only after the third red frame.
      frame(50, 5, 2, 2'd1, 2'd0, 1'b0);
      frame(50, 5, 2, 2'd1, 2'd0, 1'b0);
      frame(50, 5, 2, 2'd1, 2'd1, 1'b1);

      // Stable blue while valid is pending: result holds at red.
      frame(5, 50, 2, 2'd2, 2'd1, 1'b1);
      frame(5, 50, 2, 2'd2, 2'd1, 1'b1);
      frame(5, 50, 2, 2'd2, 2'd1, 1'b1);
      ack_pulse("ack1");
      frame(5, 50, 2, 2'd2, 2'd2, 1'b1);
      ack_pulse("ack2");

      // Threshold and tie give NONE; blue exactly at threshold is BLUE.
      frame(19, 0, 2, 2'd0, 2'd2, 1'b0);
      frame(40, 40, 2, 2'd0, 2'd2, 1'b0);
      frame(0, 20, 2, 2'd2, 2'd2, 1'b0);

      // Interrupted streak R,R,B,R,R,R: publish only after the sixth.
      frame(50, 5, 2, 2'd1, 2'd2, 1'b0);
      frame(21, 20, 2, 2'd1, 2'd2, 1'b0);
      frame(5, 50, 2, 2'd2, 2'd2, 1'b0);
      frame(50, 5, 2, 2'd1, 2'd2, 1'b0);
      frame(50, 5, 2, 2'd1, 2'd2, 1'b0);
      frame(21, 20, 2, 2'd1, 2'd1, 1'b1);

      // Long dwell on the sample line: still exactly one sample.
      frame(50, 5, 176, 2'd1, 2'd1, 1'b1);

      // Async reset mid-frame clears outputs at once and forgets the streak.
      @(negedge clk);
      bus.pixel_y = 10'd50;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("midreset_frame_class",  {6'd0, bus.frame_class},  8'd0);
      check("midreset_result",       {6'd0, bus.result},       8'd0);
      check("midreset_result_valid", {7'd0, bus.result_valid}, 8'd0);
      check("midreset_count_clear",  {7'd0, bus.count_clear},  8'd0);
      #8 rst = 1'b0;
      bus.pixel_y = 10'd80;
      idle(10);
      frame(50, 5, 2, 2'd1, 2'd0, 1'b0);

      idle(6);
      check("missing_samples", 8'(exp_q.size()), 8'd0);
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
